// File: rtl/nano_mem_loader.sv
// Word memory on the NanoCPU bus. After reset it is filled from a byte-stream loader.
// Reads are combinational (zero latency). Loader writes take effect on the LO-byte edge. CPU writes take effect on the next edge.
// ld_ready is high in every load state and low in RUN, so the loader is never stalled mid-frame.
module nano_mem_loader #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int NFRAMES = 1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] dataW,
  input  logic          ce,
  input  logic          we,
  output logic [DW-1:0] dataR,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          cpu_rst,
  output logic          load_err
);

  typedef enum logic [2:0] {
    L_ADDR = 3'd0,
    L_CNT  = 3'd1,
    L_HI   = 3'd2,
    L_LO   = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  waddr_q;
  logic [8:0]  wcnt_q;
  logic [7:0]  hi_byte_q;
  logic [7:0]  frame_cnt_q;
  logic        ld_ready_q;
  logic        cpu_rst_q;
  logic        load_err_q;

  logic [DW-1:0] mem_q [2**AW];

  logic          byte_acc;
  logic          ld_wr;
  logic          cpu_wr;
  logic [AW-1:0] ld_idx;
  logic [8:0]    wcnt_d;
  logic [7:0]    frame_cnt_d;

  // Decode the write sources. Loader and CPU writes can never coincide because they belong to different states.
  always_comb begin
    byte_acc    = ld_valid & ld_ready_q;
    ld_wr       = byte_acc && (state_q == L_LO);
    cpu_wr      = (state_q == RUN) && ce && we;
    ld_idx      = AW'(waddr_q);
    wcnt_d      = (ld_data == 8'd0) ? 9'd256 : {1'b0, ld_data};
    frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Memory array: deliberately not cleared by reset, so a partial load survives it.
  always_ff @(posedge ck) begin
    if (ld_wr) begin
      mem_q[ld_idx] <= DW'({hi_byte_q, ld_data});
    end else if (cpu_wr) begin
      mem_q[address] <= dataW;
    end
  end

  assign dataR = mem_q[address];

  // Loader FSM with registered handshake and CPU-reset outputs. It advances only on an accepted byte.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q     <= L_ADDR;
      waddr_q     <= 8'd0;
      wcnt_q      <= 9'd0;
      hi_byte_q   <= 8'd0;
      frame_cnt_q <= 8'd0;
      ld_ready_q  <= 1'b1;
      cpu_rst_q   <= 1'b1;
      load_err_q  <= 1'b0;
    end else begin
      case (state_q)
        L_ADDR: begin
          if (byte_acc) begin
            waddr_q <= ld_data;
            state_q <= L_CNT;
          end
        end
        L_CNT: begin
          if (byte_acc) begin
            wcnt_q  <= wcnt_d;
            state_q <= L_HI;
          end
        end
        L_HI: begin
          if (byte_acc) begin
            hi_byte_q <= ld_data;
            state_q   <= L_LO;
          end
        end
        L_LO: begin
          if (byte_acc) begin
            waddr_q <= waddr_q + 8'd1;
            wcnt_q  <= wcnt_q - 9'd1;
            if (wcnt_q == 9'd1) begin
              frame_cnt_q <= frame_cnt_d;
              if (frame_cnt_d == 8'(NFRAMES)) begin
                state_q    <= RUN;
                ld_ready_q <= 1'b0;
                cpu_rst_q  <= 1'b0;
              end else begin
                state_q <= L_ADDR;
              end
            end else begin
              state_q <= L_HI;
            end
          end
        end
        RUN: begin
          // Any byte offered after loading has finished is a loader protocol error.
          if (ld_valid) begin
            load_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= L_ADDR;
        end
      endcase
    end
  end

  assign ld_ready = ld_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_nano_mem_loader.sv
// Randomised bench for nano_mem_loader, built with two load frames before CPU release.
// A word-level memory model plus expected flag values are updated as stimulus is issued.
// A negedge monitor checks the flags every cycle and pops queued read expectations.
module tb_nano_mem_loader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NF = 2;

  logic          ck;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] dataW;
  logic          ce;
  logic          we;
  logic [DW-1:0] dataR;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          cpu_rst;
  logic          load_err;

  nano_mem_loader #(.AW(AW), .DW(DW), .NFRAMES(NF)) dut (
    .ck       (ck),
    .rst      (rst),
    .address  (address),
    .dataW    (dataW),
    .ce       (ce),
    .we       (we),
    .dataR    (dataR),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .load_err (load_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference model: word memory, written-address map, and expected outputs
  logic [15:0] mem_m [256];
  bit          known [256];
  int          frames_done;
  logic        exp_ready, exp_cpu, exp_err;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } rd_e_t;
  rd_e_t exp_q [$];
  rd_e_t e;
  logic  rd_vld;

  logic [15:0] frame_w [$];

  int checks;
  int errors;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: output flags every cycle, plus queued read data when a read is presented
  always @(negedge ck) begin
    check("ld_ready", {15'd0, ld_ready}, {15'd0, exp_ready});
    check("cpu_rst",  {15'd0, cpu_rst},  {15'd0, exp_cpu});
    check("load_err", {15'd0, load_err}, {15'd0, exp_err});
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        check("rd_queue_empty", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("dataR@%h", e.a), dataR, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = $urandom_range(0, 2);
    ld_valid = 1'b0;
    repeat (n) begin @(posedge ck); #1; end
    ld_valid = 1'b1;
    ld_data  = b;
    @(posedge ck); #1;
    ld_valid = 1'b0;
    ld_data  = 8'($urandom);
  endtask

  // Sends one frame of frame_w[0..n-1] starting at address a. Count 256 goes on the wire as 0.
  task automatic send_frame(input logic [7:0] a, input int n);
    send_byte(a);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      send_byte(frame_w[i][15:8]);
      send_byte(frame_w[i][7:0]);
      mem_m[(a + i) % 256] = frame_w[i];
      known[(a + i) % 256] = 1'b1;
    end
    frames_done++;
    if (frames_done == NF) begin
      exp_ready = 1'b0;
      exp_cpu   = 1'b0;
    end
  endtask

  task automatic rd_check(input logic [7:0] a);
    rd_e_t r;
    @(posedge ck); #1;
    address = a;
    r.a = a;
    r.d = mem_m[a];
    exp_q.push_back(r);
    rd_vld = 1'b1;
    @(posedge ck); #1;
    rd_vld = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    @(posedge ck); #1;
    address = a;
    dataW   = d;
    ce      = 1'b1;
    we      = 1'b1;
    @(posedge ck); #1;
    ce = 1'b0;
    we = 1'b0;
    if (!exp_cpu) mem_m[a] = d;
  endtask

  task automatic do_reset();
    @(posedge ck); #1;
    rst         = 1'b0;
    ld_valid    = 1'b0;
    exp_ready   = 1'b1;
    exp_cpu     = 1'b1;
    exp_err     = 1'b0;
    frames_done = 0;
    @(posedge ck); #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] a;
    checks = 0; errors = 0;
    rst = 1'b0; address = '0; dataW = '0; ce = 1'b0; we = 1'b0;
    ld_valid = 1'b0; ld_data = 8'd0; rd_vld = 1'b0;
    exp_ready = 1'b1; exp_cpu = 1'b1; exp_err = 1'b0; frames_done = 0;
    for (int i = 0; i < 256; i++) begin mem_m[i] = 16'd0; known[i] = 1'b0; end

    repeat (3) @(posedge ck);
    #1 rst = 1'b1;
    repeat (20) @(posedge ck);
    #1;

    // First frame: 00,02,01E0,01F1. The CPU is still held after it, and reads work during load.
    frame_w = '{16'h01E0, 16'h01F1};
    send_frame(8'h00, 2);
    rd_check(8'h00);
    rd_check(8'h01);
    repeat (5) @(posedge ck);
    #1;
    // Second frame releases the CPU
    frame_w = '{16'h1111, 16'h2222};
    send_frame(8'h1E, 2);
    rd_check(8'h1E);
    rd_check(8'h1F);

    // CPU write in RUN
    cpu_write(8'h20, 16'hABCD);
    rd_check(8'h20);

    // A loader byte in RUN sets load_err, and it stays set
    @(posedge ck); #1;
    ld_valid = 1'b1;
    @(posedge ck); #1;
    ld_valid = 1'b0;
    exp_err  = 1'b1;
    repeat (5) @(posedge ck);
    #1;

    // After reset, a CPU write during load is ignored
    do_reset();
    cpu_write(8'h20, 16'h5555);
    rd_check(8'h20);
    // A partial frame followed by reset leaves mem[0] untouched
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    do_reset();
    rd_check(8'h00);

    // Wrapping frame with COUNT=0 (256 words, word i = i) starting at FF
    frame_w.delete();
    for (int i = 0; i < 256; i++) frame_w.push_back(16'(i));
    send_frame(8'hFF, 256);
    rd_check(8'hFF);
    rd_check(8'h00);
    rd_check(8'hFE);

    // Random second frame
    frame_w.delete();
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) frame_w.push_back(16'($urandom));
    a = 8'($urandom);
    send_frame(a, n);
    for (int i = 0; i < n; i++) rd_check(8'(a + 8'(i)));

    // Random CPU writes and reads in RUN
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      cpu_write(a, 16'($urandom));
      rd_check(a);
    end
    for (int i = 0; i < 20; i++) rd_check(8'($urandom));

    repeat (3) @(posedge ck);
    if (exp_q.size() != 0) check("rd_queue_drain", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
